// File: rtl/rv32i_inst_mem.sv
// rv32i_inst_mem: word-addressed instruction RAM answering fetch strobes after WAIT_STATES cycles.
module rv32i_inst_mem #(
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] OOR_INST    = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stb_inst,
    input  logic [31:0] i_iaddr,
    output logic [31:0] o_inst,
    output logic        o_ack_inst,
    input  logic        i_wr_en,
    input  logic [31:0] i_wr_addr,
    input  logic [31:0] i_wr_data
);
    localparam int          IW   = $clog2(MEM_DEPTH);
    localparam logic [32:0] SPAN = 33'(MEM_DEPTH) << 2;
    localparam logic [3:0]  WS   = 4'(WAIT_STATES);

    typedef enum logic {IDLE, BUSY} state_t;

    logic [31:0] mem_q [MEM_DEPTH];
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] inst_q, inst_d;
    logic        ack_q, ack_d;

    function automatic logic in_range(input logic [31:0] a);
        return (a >= BASE_ADDR) && ((33'(a) - 33'(BASE_ADDR)) < SPAN);
    endfunction

    function automatic logic [IW-1:0] index(input logic [31:0] a);
        return IW'((a - BASE_ADDR) >> 2);
    endfunction

    // Combinational read of the current array gives read-first on a same-cycle write.
    function automatic logic [31:0] word(input logic [31:0] a);
        return in_range(a) ? mem_q[index(a)] : OOR_INST;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_wr_en && in_range(i_wr_addr))
            mem_q[index(i_wr_addr)] <= i_wr_data;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        inst_d  = inst_q;
        ack_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_stb_inst) begin
                    if (WAIT_STATES == 0) begin
                        ack_d  = 1'b1;
                        inst_d = word(i_iaddr);
                    end else begin
                        addr_d  = i_iaddr;
                        cnt_d   = WS;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!i_stb_inst) begin
                    state_d = IDLE;
                end else if (i_iaddr != addr_q) begin
                    addr_d = i_iaddr;
                    cnt_d  = WS;
                end else if (cnt_q == 4'd1) begin
                    ack_d   = 1'b1;
                    inst_d  = word(addr_q);
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            inst_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            ack_q   <= ack_d;
        end
    end

    assign o_inst     = inst_q;
    assign o_ack_inst = ack_q;
endmodule

// File: tb/tb_rv32i_inst_mem.sv
// tb_rv32i_inst_mem: scoreboard bench over three configurations (no wait, two waits, windowed three waits).
module tb_rv32i_inst_mem;
    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    exp_t qa[$], qb[$], qc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        a_rst_n, a_stb, a_ack, a_we;
    logic [31:0] a_addr, a_inst, a_waddr, a_wdata;
    logic        b_rst_n, b_stb, b_ack, b_we;
    logic [31:0] b_addr, b_inst, b_waddr, b_wdata;
    logic        c_rst_n, c_stb, c_ack, c_we;
    logic [31:0] c_addr, c_inst, c_waddr, c_wdata;

    rv32i_inst_mem #(.MEM_DEPTH(16), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_a (
        .i_clk(clk), .i_rst_n(a_rst_n), .i_stb_inst(a_stb), .i_iaddr(a_addr),
        .o_inst(a_inst), .o_ack_inst(a_ack), .i_wr_en(a_we), .i_wr_addr(a_waddr), .i_wr_data(a_wdata));
    rv32i_inst_mem #(.MEM_DEPTH(32), .BASE_ADDR(32'h0), .WAIT_STATES(2)) u_b (
        .i_clk(clk), .i_rst_n(b_rst_n), .i_stb_inst(b_stb), .i_iaddr(b_addr),
        .o_inst(b_inst), .o_ack_inst(b_ack), .i_wr_en(b_we), .i_wr_addr(b_waddr), .i_wr_data(b_wdata));
    rv32i_inst_mem #(.MEM_DEPTH(16), .BASE_ADDR(32'h1000), .WAIT_STATES(3)) u_c (
        .i_clk(clk), .i_rst_n(c_rst_n), .i_stb_inst(c_stb), .i_iaddr(c_addr),
        .o_inst(c_inst), .o_ack_inst(c_ack), .i_wr_en(c_we), .i_wr_addr(c_waddr), .i_wr_data(c_wdata));

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitors: every ack must match the head of its queue in both cycle and data.
    always @(negedge clk) begin
        exp_t e;
        if (a_ack === 1'b1) begin
            if (qa.size() == 0) chk("a unexpected ack", 32'd1, 32'd0);
            else begin
                e = qa.pop_front();
                chk("a ack cycle", 32'(cyc), 32'(e.cyc));
                chk("a inst", a_inst, e.data);
            end
        end
        if (b_ack === 1'b1) begin
            if (qb.size() == 0) chk("b unexpected ack", 32'd1, 32'd0);
            else begin
                e = qb.pop_front();
                chk("b ack cycle", 32'(cyc), 32'(e.cyc));
                chk("b inst", b_inst, e.data);
            end
        end
        if (c_ack === 1'b1) begin
            if (qc.size() == 0) chk("c unexpected ack", 32'd1, 32'd0);
            else begin
                e = qc.pop_front();
                chk("c ack cycle", 32'(cyc), 32'(e.cyc));
                chk("c inst", c_inst, e.data);
            end
        end
    end

    logic [31:0] b_wa [4] = '{32'h8, 32'h4, 32'h40, 32'h0};
    logic [31:0] b_wd [4] = '{32'h33, 32'h22, 32'h4040, 32'h11};
    logic [31:0] c_wa [4] = '{32'h1000, 32'h1040, 32'h0FFC, 32'h1004};
    logic [31:0] c_wd [4] = '{32'hC0, 32'hDEAD, 32'hBAD, 32'hC4};

    initial begin
        {a_rst_n, a_stb, a_we, a_addr, a_waddr, a_wdata} = '0;
        {b_rst_n, b_stb, b_we, b_addr, b_waddr, b_wdata} = '0;
        {c_rst_n, c_stb, c_we, c_addr, c_waddr, c_wdata} = '0;
        tick(3);
        chk("a reset ack", 32'(a_ack), 32'd0);
        chk("a reset inst", a_inst, 32'd0);
        chk("b reset ack", 32'(b_ack), 32'd0);
        chk("b reset inst", b_inst, 32'd0);
        chk("c reset ack", 32'(c_ack), 32'd0);
        chk("c reset inst", c_inst, 32'd0);
        a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_we = 1'b1; a_waddr = 32'(i * 4); a_wdata = 32'((i + 1) * 'h11);
            b_we = 1'b1; b_waddr = b_wa[i]; b_wdata = b_wd[i];
            c_we = 1'b1; c_waddr = c_wa[i]; c_wdata = c_wd[i];
            tick();
        end
        a_we = 1'b0; b_we = 1'b0; c_we = 1'b0;
        tick();

        // Zero wait states: four back-to-back fetches, one ack per cycle.
        for (int i = 0; i < 4; i++) begin
            a_stb = 1'b1; a_addr = 32'(i * 4);
            qa.push_back('{cyc + 1, 32'((i + 1) * 'h11)});
            tick();
        end
        a_stb = 1'b0;
        tick(2);
        // Read-first collision.
        a_we = 1'b1; a_waddr = 32'h0; a_wdata = 32'hAAAA;
        tick();
        a_wdata = 32'hBBBB; a_stb = 1'b1; a_addr = 32'h0;
        qa.push_back('{cyc + 1, 32'hAAAA});
        tick();
        a_we = 1'b0;
        qa.push_back('{cyc + 1, 32'hBBBB});
        tick();
        a_stb = 1'b0;
        tick(2);

        // Two wait states: single request, ack exactly in k+3, gone in k+4.
        b_stb = 1'b1; b_addr = 32'h8;
        qb.push_back('{cyc + 3, 32'h33});
        tick(3);
        b_stb = 1'b0;
        tick();
        chk("b ack dropped", 32'(b_ack), 32'd0);
        tick(2);
        // Restart on address change.
        b_stb = 1'b1; b_addr = 32'h4;
        tick();
        b_addr = 32'h40;
        qb.push_back('{cyc + 3, 32'h4040});
        tick(3);
        b_stb = 1'b0;
        tick(2);
        // Strobe held: one word per three cycles.
        b_stb = 1'b1; b_addr = 32'h8;
        qb.push_back('{cyc + 3, 32'h33});
        qb.push_back('{cyc + 6, 32'h33});
        tick(6);
        b_stb = 1'b0;
        tick(2);
        // Abort: strobe dropped while busy yields no ack.
        b_stb = 1'b1; b_addr = 32'h4;
        tick();
        b_stb = 1'b0;
        tick(4);

        // Windowed memory, out-of-range fetches below and above the window.
        c_stb = 1'b1; c_addr = 32'h0FFC;
        qc.push_back('{cyc + 4, 32'h13});
        tick(4);
        c_addr = 32'h1040;
        qc.push_back('{cyc + 4, 32'h13});
        tick(4);
        c_addr = 32'h1000;
        qc.push_back('{cyc + 4, 32'hC0});
        tick(4);
        c_addr = 32'h1004;
        qc.push_back('{cyc + 4, 32'hC4});
        tick(4);
        c_stb = 1'b0;
        tick(2);
        // Write to the latched word while busy is visible in the response.
        c_stb = 1'b1; c_addr = 32'h1008;
        qc.push_back('{cyc + 4, 32'h88});
        tick();
        c_we = 1'b1; c_waddr = 32'h1008; c_wdata = 32'h88;
        tick();
        c_we = 1'b0;
        tick(2);
        c_stb = 1'b0;
        tick(2);
        // Reset mid-request aborts it and clears the output word.
        c_stb = 1'b1; c_addr = 32'h1004;
        tick(2);
        c_rst_n = 1'b0; c_stb = 1'b0;
        tick();
        chk("c mid reset ack", 32'(c_ack), 32'd0);
        chk("c mid reset inst", c_inst, 32'd0);
        c_rst_n = 1'b1;
        tick(3);
        chk("c post reset ack", 32'(c_ack), 32'd0);
        c_stb = 1'b1; c_addr = 32'h1000;
        qc.push_back('{cyc + 4, 32'hC0});
        tick(4);
        c_stb = 1'b0;
        tick(4);

        chk("a queue drained", 32'(qa.size()), 32'd0);
        chk("b queue drained", 32'(qb.size()), 32'd0);
        chk("c queue drained", 32'(qc.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/rv32i_inst_mem.md
Name: rv32i_inst_mem

Overview:
- Instruction-memory responder: the slave end of the fetch stage's instruction bus (strobe / address / ack / instruction).
- Holds a word-addressed instruction RAM. It answers fetch strobes after a configurable number of wait states and returns a NOP for addresses outside its window.
- A separate write port lets a loader or testbench fill the RAM.
- Sits between the fetch stage and the program memory in the rv32i core top level.

Parameters:
- MEM_DEPTH, 1024, number of 32-bit words; must be a power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to MEM_DEPTH*4.
- WAIT_STATES, 0, extra cycles before ack; range 0..15.
- OOR_INST, 32'h0000_0013, word returned for out-of-range fetches (addi x0,x0,0).

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_stb_inst  input  1  fetch request; may stay high continuously.
- i_iaddr  input  32  instruction byte address; bits [1:0] ignored.
- o_inst  output  32  instruction word; valid when o_ack_inst=1.
- o_ack_inst  output  1  one-cycle pulse per completed request.
- i_wr_en  input  1  loader word write enable.
- i_wr_addr  input  32  loader byte address; bits [1:0] ignored.
- i_wr_data  input  32  loader write data.

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - o_ack_inst=0, o_inst=0, state=IDLE, wait counter=0, latched address=0.
  - RAM contents are not cleared.
  - Reset during BUSY aborts the request; no ack follows.
- Address decode:
  - Index = (addr-BASE_ADDR)>>2.
  - In range iff BASE_ADDR <= addr <= BASE_ADDR+MEM_DEPTH*4-1, compared in 32-bit unsigned.
  - Out of range: reads return OOR_INST; writes are dropped.
- Latency: a request accepted in cycle k has o_ack_inst=1 in cycle k+1+WAIT_STATES.
- FSM IDLE:
  - i_stb_inst=0: o_ack_inst<=0.
  - i_stb_inst=1 and WAIT_STATES=0: o_ack_inst<=1, o_inst<=word(i_iaddr); stay IDLE. Result is one ack per cycle, fully pipelined.
  - i_stb_inst=1 and WAIT_STATES>0: latch i_iaddr, cnt<=WAIT_STATES, o_ack_inst<=0, go to BUSY.
- FSM BUSY (o_ack_inst held 0 unless completing):
  - i_stb_inst=0: abort, go to IDLE; no ack.
  - i_stb_inst=1 and i_iaddr != latched address: relatch the new address, reload cnt<=WAIT_STATES, stay BUSY. This is a restart, covering PC change or flush.
  - Otherwise, cnt==1: o_ack_inst<=1, o_inst<=word(latched address), go to IDLE.
  - Otherwise: cnt<=cnt-1.
- Back-to-back requests: the ack cycle is an IDLE cycle. With i_stb_inst still high, the next address is accepted in that same cycle, giving a throughput of one word per WAIT_STATES+1 cycles.
- o_inst holds its last value between acks and is only meaningful while o_ack_inst=1.
- Write port:
  - Independent of the FSM; writes are accepted in any state, including during reset deassertion.
  - Same-cycle write and read of the same word: the read returns the old data (read-first).
  - A write landing while BUSY on the latched word, before the completing cycle, is visible in the response.
- No other state; no error output.

Test Plan:
- WAIT_STATES=0: load words 0..3 = 0x11,0x22,0x33,0x44. Hold stb=1 with addr 0,4,8,12 on consecutive cycles -> ack=1 for 4 consecutive cycles starting one cycle later, o_inst=0x11,0x22,0x33,0x44.
- WAIT_STATES=2, single request to addr 0x8 at cycle k -> ack only in cycle k+3, o_inst=0x33. Ack lasts exactly one cycle; if stb drops in k+3, ack is 0 in k+4.
- WAIT_STATES=2: request 0x4 at cycle k, change addr to 0x40 at k+1 -> no ack for 0x4; ack at k+4 with word(0x40).
- Out-of-range: BASE_ADDR=0x1000, MEM_DEPTH=16. Fetch 0x0FFC and 0x1040 -> o_inst=0x0000_0013 each. Write to 0x1040 -> RAM unchanged.
- Reset mid-op: WAIT_STATES=3, request at k, i_rst_n=0 at k+2 -> no ack, o_inst=0, state IDLE. A new request after release is acked after 4 cycles.
- Read/write collision: WAIT_STATES=0, word at 0x0=0xAAAA. Same cycle write 0xBBBB to 0x0 and fetch 0x0 -> o_inst=0xAAAA. The following fetch returns 0xBBBB.
